// File: rtl/layer_ctrl_pkg.sv
// Shared definitions for the layer mode controller.
//  - state_t    : controller phases (IDLE, ARM, RUN, DONE)
//  - is_onehot  : true when exactly one bit of a mode word is set
//  - onehot2bin : binary index of the set bit of a one-hot word
// The helpers work on a fixed MAX_PE-wide vector. Callers zero-extend
// narrower engine vectors, so one function body serves every N_PE.
package layer_ctrl_pkg;

  localparam int MAX_PE    = 32;
  localparam int MAX_SEL_W = $clog2(MAX_PE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Clearing the lowest set bit leaves zero only for words with a single bit.
  function automatic logic is_onehot(input logic [MAX_PE-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_PE'(1))) == '0);
  endfunction

  // OR of the indices of all set bits; exact for one-hot inputs and cheaper
  // than a priority chain.
  function automatic logic [MAX_SEL_W-1:0] onehot2bin(input logic [MAX_PE-1:0] vec);
    logic [MAX_SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PE; i++) begin
      if (vec[i]) idx = idx | MAX_SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot to binary encoder.
//  vec   in  N_PE   one-hot candidate word
//  idx   out SEL_W  binary index of the set bit (meaningful when valid=1)
//  valid out 1      exactly one bit of vec is set
module onehot_enc
  import layer_ctrl_pkg::*;
#(
  parameter int N_PE  = 4,
  parameter int SEL_W = $clog2(N_PE)
) (
  input  logic [N_PE-1:0]  vec,
  output logic [SEL_W-1:0] idx,
  output logic             valid
);

  logic [MAX_PE-1:0]    vec_ext;
  logic [MAX_SEL_W-1:0] idx_full;

  assign vec_ext  = MAX_PE'(vec);
  assign idx_full = onehot2bin(vec_ext);
  assign idx      = idx_full[SEL_W-1:0];
  assign valid    = is_onehot(vec_ext);

  // High index bits are always zero for an N_PE-wide input.
  generate
    if (SEL_W < MAX_SEL_W) begin : g_idx_hi
      logic unused_idx_hi;
      assign unused_idx_hi = ^idx_full[MAX_SEL_W-1:SEL_W];
    end
  endgenerate

endmodule

// File: rtl/layer_mode_ctrl.sv
// Layer-level mode controller for the accelerator compute engines.
// Accepts a one-hot mode word per layer, drives the output-mux select
// (Switch0) and the active-low engine enables (Switch1), forwards the DMA
// start strobes and Last from the selected engine, and reports layer
// progress and error pulses.
//  clk, rst            clock, synchronous active-high reset
//  Switch, cfg_valid   mode word (bits [N_PE-1:0] one-hot) and its strobe
//  cfg_ready           idle, a new mode word will be accepted
//  Switch0, Switch1    binary mux select, active-low engine enables
//  PE_DMA_Read_Start,
//  PE_DMA_Write_Start,
//  PE_Last             per-engine strobes
//  DMA_Read_Start,
//  DMA_Write_Start,
//  M_Last              strobes of the selected engine, one cycle later
//  busy, layer_done    layer in progress / end-of-layer pulse
//  mode_err, stray_err illegal mode word / strobe from a deselected engine
module layer_mode_ctrl
  import layer_ctrl_pkg::*;
#(
  parameter int N_PE  = 4,
  parameter int SEL_W = $clog2(N_PE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Switch,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [SEL_W-1:0] Switch0,
  output logic [N_PE-1:0]  Switch1,
  input  logic [N_PE-1:0]  PE_DMA_Read_Start,
  input  logic [N_PE-1:0]  PE_DMA_Write_Start,
  input  logic [N_PE-1:0]  PE_Last,
  output logic             DMA_Read_Start,
  output logic             DMA_Write_Start,
  output logic             M_Last,
  output logic             busy,
  output logic             layer_done,
  output logic             mode_err,
  output logic             stray_err
);

  state_t            state_reg, state_next;
  logic [N_PE-1:0]   mode_q_reg;
  logic [SEL_W-1:0]  switch0_reg;
  logic [N_PE-1:0]   switch1_reg;
  logic              rd_reg, wr_reg, last_reg;
  logic              done_reg, mode_err_reg, stray_reg;

  logic [N_PE-1:0]   enc_in;
  logic [SEL_W-1:0]  enc_idx;
  logic              enc_valid;
  logic [N_PE-1:0]   stray_vec;
  logic              in_idle, in_run;

  assign in_idle = (state_reg == IDLE);
  assign in_run  = (state_reg == RUN);

  // One encoder serves both uses: in IDLE it qualifies the incoming word,
  // afterwards it encodes the captured mode for the ARM register load.
  assign enc_in = in_idle ? Switch[N_PE-1:0] : mode_q_reg;

  onehot_enc #(
    .N_PE  (N_PE),
    .SEL_W (SEL_W)
  ) u_enc (
    .vec   (enc_in),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Switch1 is 1 exactly on the deselected engines, so it doubles as the
  // stray-strobe mask.
  for (genvar gi = 0; gi < N_PE; gi++) begin : g_stray
    assign stray_vec[gi] = switch1_reg[gi] &
                           (PE_DMA_Read_Start[gi] | PE_DMA_Write_Start[gi] | PE_Last[gi]);
  end

  // Mode bits above N_PE are ignored by design.
  generate
    if (N_PE < 32) begin : g_switch_hi
      logic unused_switch_hi;
      assign unused_switch_hi = ^Switch[31:N_PE];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cfg_valid && enc_valid) state_next = ARM;
      ARM:     state_next = RUN;
      RUN:     if (PE_Last[switch0_reg]) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      mode_q_reg   <= '0;
      switch0_reg  <= '0;
      switch1_reg  <= '1;
      rd_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      last_reg     <= 1'b0;
      done_reg     <= 1'b0;
      mode_err_reg <= 1'b0;
      stray_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_err_reg <= in_idle && cfg_valid && !enc_valid;
      if (in_idle && cfg_valid) mode_q_reg <= Switch[N_PE-1:0];
      if (state_reg == ARM) begin
        switch0_reg <= enc_idx;
        switch1_reg <= ~mode_q_reg;
      end
      // Forwarding is gated to RUN so strobes seen in other phases are dropped.
      rd_reg    <= in_run && PE_DMA_Read_Start[switch0_reg];
      wr_reg    <= in_run && PE_DMA_Write_Start[switch0_reg];
      last_reg  <= in_run && PE_Last[switch0_reg];
      stray_reg <= in_run && (|stray_vec);
      // DONE lasts one cycle, so this pulse lands one cycle after M_Last.
      done_reg  <= (state_reg == DONE);
    end
  end

  assign cfg_ready       = in_idle;
  assign busy            = !in_idle;
  assign Switch0         = switch0_reg;
  assign Switch1         = switch1_reg;
  assign DMA_Read_Start  = rd_reg;
  assign DMA_Write_Start = wr_reg;
  assign M_Last          = last_reg;
  assign layer_done      = done_reg;
  assign mode_err        = mode_err_reg;
  assign stray_err       = stray_reg;

endmodule
